// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants and the symbolic instruction kinds shared by
// the program loader and the control-path decoder.
package rv_isa_pkg;

  typedef enum logic [2:0] {
    K_LW  = 3'd0,
    K_SW  = 3'd1,
    K_ADD = 3'd2,
    K_SUB = 3'd3,
    K_AND = 3'd4,
    K_OR  = 3'd5,
    K_SLT = 3'd6,
    K_BEQ = 3'd7
  } kind_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } load_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/rv_instr_encode.sv
// Combinational encoder: symbolic instruction kind plus fields -> RV32I word.
module rv_instr_encode
  import rv_isa_pkg::*;
(
  input  kind_t       kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word
);

  // Branch offsets are halfword aligned, so the LSB never reaches the word.
  logic unused_imm_lsb;
  assign unused_imm_lsb = imm[0];

  always_comb begin
    word = '0;
    case (kind)
      K_LW:  word = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
      K_SW:  word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
      K_ADD: word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OP_RTYPE};
      K_SUB: word = {F7_SUB, rs2, rs1, F3_ADD_SUB, rd, OP_RTYPE};
      K_AND: word = {F7_BASE, rs2, rs1, F3_AND, rd, OP_RTYPE};
      K_OR:  word = {F7_BASE, rs2, rs1, F3_OR, rd, OP_RTYPE};
      K_SLT: word = {F7_BASE, rs2, rs1, F3_SLT, rd, OP_RTYPE};
      K_BEQ: word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes a stream of symbolic requests and writes the
// words sequentially into instruction memory from BASE_ADDR.
//
// state | meaning
// IDLE  | out of reset, waiting for start
// LOAD  | accepting requests, one memory write per accept
// DONE  | session closed by in_last or by reaching DEPTH; start reopens
module instr_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int                 DEPTH     = 64,
  localparam int                CW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              illegal
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  load_state_t       state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word;
  logic              accept;
  logic              at_limit;

  rv_instr_encode u_encode (
    .kind (kind_t'(in_kind)),
    .rd   (in_rd),
    .rs1  (in_rs1),
    .rs2  (in_rs2),
    .imm  (in_imm),
    .word (word)
  );

  // Each accept is written on the same edge, so nothing is ever pending
  // and the limit check needs only the committed count.
  assign in_ready = (state == S_LOAD) && (count < DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign at_limit = (count == DEPTH_C - 1'b1);
  assign busy     = (state == S_LOAD);
  assign done     = (state == S_DONE);
  assign illegal  = 1'b0;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  if (accept && (in_last || at_limit)) state_nx = S_DONE;
      S_DONE:  if (start) state_nx = S_LOAD;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      addr      <= BASE_ADDR;
      count     <= '0;
      overflow  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_nx;
      mem_we <= accept;
      if (accept) begin
        mem_addr  <= addr;
        mem_wdata <= word;
        addr      <= addr + ADDR_W'(4);
        count     <= count + 1'b1;
        if (at_limit && !in_last) overflow <= 1'b1;
      end
      if (start && (state != S_LOAD)) begin
        addr     <= BASE_ADDR;
        count    <= '0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the control-path decode: takes symbolic instruction requests (kind, rd, rs1, rs2, imm) over a valid/ready stream and encodes each into a 32-bit RV32I word.
- Writes the words sequentially into instruction memory through a registered write port, advancing the address by 4 from a base.
- Sits between the testbench or boot controller and instruction memory, and loads programs for the single-cycle core.
- Supported kinds: LW, SW, ADD, SUB, AND, OR, SLT, BEQ.

Parameters:
- ADDR_W, 32, byte-address width of the memory write port.
- BASE_ADDR, 0, byte address of the first word written after start.
- DEPTH, 64, maximum words per load session; a power of two is not required.

Ports:
- clk  in  1  Rising-edge clock; the only clock.
- rst  in  1  Asynchronous, active-low reset.
- start  in  1  Single-cycle pulse that opens a load session.
- in_valid  in  1  Request valid.
- in_ready  out  1  Request accepted when in_valid & in_ready are both high at a clock edge.
- in_kind  in  3  0=LW 1=SW 2=ADD 3=SUB 4=AND 5=OR 6=SLT 7=BEQ.
- in_rd, in_rs1, in_rs2  in  5 each  Register indices.
- in_imm  in  13  Signed immediate. LW/SW use [11:0]. BEQ uses [12:1] as a byte offset; bit 0 is ignored.
- in_last  in  1  Marks the final request of the session.
- mem_we  out  1  Write strobe, one cycle per word.
- mem_addr  out  ADDR_W  Byte address of the write.
- mem_wdata  out  32  Encoded instruction.
- busy  out  1  High in LOAD.
- done  out  1  High in DONE.
- count  out  $clog2(DEPTH+1)  Words written this session.
- overflow  out  1  Sticky: DEPTH was reached without in_last.
- illegal  out  1  Sticky: reserved. With a 3-bit in_kind all codes are legal; the flag exists for a future width increase and is tied to 0 now.

Behaviour:
- Reset (async, rst=0): state=IDLE; all outputs 0; the internal address register = BASE_ADDR.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: on start, go to LOAD; addr=BASE_ADDR, count=0, overflow=0.
  - LOAD: in_ready = 1 while count + pending < DEPTH.
  - DONE: on start, go to LOAD with the same initialisation as from IDLE.
  - start during LOAD is ignored.
- Handshake: the request is accepted at edge N. At edge N+1 the outputs are registered: mem_we=1, mem_addr=addr, mem_wdata=encoded word. Also at edge N+1, addr += 4 and count += 1. Latency is exactly 1 cycle. Back-to-back accepts give one write per cycle.
- in_ready is combinational from state and count only. It never depends on in_valid.
- Session end:
  - An accepted request with in_last=1 moves the FSM to DONE at edge N+1, together with its write.
  - If the write that makes count == DEPTH has in_last=0: set overflow=1, go to DONE. No further requests are accepted.
  - If count == DEPTH is reached with in_last=1: go to DONE, overflow=0.
- Address arithmetic: addr wraps modulo 2^ADDR_W with no flag. count never exceeds DEPTH.
- Encoding rules:
  - LW: {imm[11:0], rs1, 010, rd, 0000011}
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}
  - R-type: {f7, rs2, rs1, f3, rd, 0110011}, with ADD f7=0000000 f3=000; SUB f7=0100000 f3=000; AND f3=111; OR f3=110; SLT f3=010.
  - BEQ: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}
  - Fields unused by a kind (rd for SW/BEQ, rs2 for LW, imm for R-type) are ignored.
- mem_we is low in every cycle with no accepted request on the previous edge.
- Reset mid-session: any pending write is dropped and memory is not written. Memory contents are outside this block's control.

Decomposition:
- Shared package rv_isa_pkg holds:
  - opcode constants: OP_LOAD=0000011, OP_STORE=0100011, OP_RTYPE=0110011, OP_BRANCH=1100011;
  - funct3/funct7 constants;
  - the kind enum.
- The main decoder uses the same package.
- One combinational sub-module, rv_instr_encode (kind + fields -> 32-bit word), so it can be unit-tested against the decoder. The FSM, counters and output registers stay in the top.

Test Plan:
1. Reset then start; send LW rd=6 rs1=9 imm=0xFFC (-4), last=0 -> next cycle mem_we=1, addr=0x0, wdata=0xFFC4A303, count=1.
2. Back-to-back without gaps: SW rs2=6 rs1=9 imm=8, ADD rd=4 rs1=5 rs2=6, SUB rd=7 rs1=2 rs2=3 -> writes 0x0064A423 @0x4, 0x00628233 @0x8, 0x403103B3 @0xC on consecutive cycles.
3. BEQ rs1=1 rs2=2 imm=8 with last=1 -> wdata=0x00208463; then done=1, busy=0, in_ready=0, and further in_valid causes no writes.
4. DEPTH=4, five requests with last=0 -> exactly 4 writes, overflow=1, done=1, 5th request never accepted.
5. Assert rst=0 in the cycle after an accept -> no mem_we; all outputs 0 immediately; after release and start, first write is at BASE_ADDR.
6. Pulse start during LOAD -> ignored, addresses continue. Pulse start in DONE -> count=0, overflow=0, next write at BASE_ADDR.
